// File: rtl/mux_arbiter_2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter_2_pkg : shared state encodings and default sizing constants
// Rev 1.0
// ----------------------------------------------------------------------------
package mux_arbiter_2_pkg;

  localparam int unsigned c_DEF_W         = 8;
  localparam int unsigned c_DEF_MAX_BURST = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_2_mux2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter_2_mux2 : single-bit 2:1 data multiplexer
// Rev 1.0
// ----------------------------------------------------------------------------
module mux_arbiter_2_mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/mux_arbiter_2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter_2 : two-requester round-robin burst arbiter with registered mux out
// Rev 1.0
// ----------------------------------------------------------------------------
module mux_arbiter_2
  import mux_arbiter_2_pkg::*;
#(
  parameter int unsigned W         = c_DEF_W,
  parameter int unsigned MAX_BURST = c_DEF_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   i_req,
  input  logic [1:0]   i_last,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [1:0]   o_gnt,
  output logic         o_sel,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  localparam logic [3:0] c_MAX = 4'(MAX_BURST);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_sel;
  logic           w_sel_nxt;
  logic           r_pri;
  logic           w_pri_nxt;
  logic [3:0]     r_beats;
  logic [3:0]     w_beats_nxt;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic [W-1:0]   w_mux_y;
  logic           w_accept;
  logic           w_take;
  logic           w_burst_end;

  assign w_accept    = ~r_out_valid | i_out_ready;
  assign w_take      = (r_state == ST_BUSY) & i_req[r_sel] & w_accept;
  assign w_burst_end = w_take & (i_last[r_sel] | ((r_beats + 4'd1) == c_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_pri   <= 1'b0;
      r_beats <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_pri   <= w_pri_nxt;
      r_beats <= w_beats_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pri_nxt   = r_pri;
    w_beats_nxt = r_beats;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_sel_nxt   = i_req[r_pri] ? r_pri : ~r_pri;
          w_beats_nxt = 4'd0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An abandoning requester ends the grant without a beat this cycle.
        if (!i_req[r_sel]) begin
          w_state_nxt = ST_IDLE;
          w_pri_nxt   = ~r_sel;
        end else if (w_take) begin
          w_beats_nxt = r_beats + 4'd1;
          if (w_burst_end) begin
            w_state_nxt = ST_IDLE;
            w_pri_nxt   = ~r_sel;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_gnt = (r_state == ST_BUSY) ? onehot2(r_sel) : 2'b00;
  assign o_sel = r_sel;

  for (genvar gi = 0; gi < int'(W); gi++) begin : g_mux
    mux_arbiter_2_mux2 u_mux (
      .i_a  (i_d0[gi]),
      .i_b  (i_d1[gi]),
      .i_sel(r_sel),
      .o_y  (w_mux_y[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_y;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter_2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux_arbiter_2 : scoreboard bench for mux_arbiter_2 (MAX_BURST=4 and =1)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mux_arbiter_2;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] last = 2'b00;
  logic       ready = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;

  logic [1:0] gnt, gnt1;
  logic       sel, sel1, ov, ov1;
  logic [7:0] od, od1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_q[$];
  logic       m_busy, m_sel, m_pri, m_valid;
  logic [3:0] m_beats;

  always #5 clk = ~clk;

  mux_arbiter_2 #(.W(8), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_last(last), .i_d0(d0), .i_d1(d1),
    .o_gnt(gnt), .o_sel(sel), .o_out_valid(ov), .i_out_ready(ready), .o_out_data(od)
  );

  mux_arbiter_2 #(.W(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_last(last), .i_d0(d0), .i_d1(d1),
    .o_gnt(gnt1), .o_sel(sel1), .o_out_valid(ov1), .i_out_ready(ready), .o_out_data(od1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_sel   = 1'b0;
    m_pri   = 1'b0;
    m_beats = 4'd0;
    m_valid = 1'b0;
    sb_q.delete();
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic rd,
                      input logic [7:0] a, input logic [7:0] b);
    logic       acc, took, n_busy, n_sel, n_pri, n_valid;
    logic [3:0] n_beats;
    req = r; last = l; ready = rd; d0 = a; d1 = b;
    #1;
    chk("gnt", gnt, m_busy ? (m_sel ? 2'b10 : 2'b01) : 2'b00);
    chk("sel", sel, m_sel);
    chk("out_valid", ov, m_valid);
    if (m_valid) begin
      if (sb_q.size() == 0) chk("sb_depth", sb_q.size(), 1);
      else begin
        chk("out_data", od, sb_q[0]);
        if (rd) void'(sb_q.pop_front());
      end
    end
    acc = !m_valid || rd;
    took = 1'b0;
    n_busy = m_busy; n_sel = m_sel; n_pri = m_pri; n_beats = m_beats;
    if (!m_busy) begin
      if (r != 2'b00) begin
        n_sel   = r[m_pri] ? m_pri : !m_pri;
        n_busy  = 1'b1;
        n_beats = 4'd0;
      end
    end else if (!r[m_sel]) begin
      n_busy = 1'b0;
      n_pri  = !m_sel;
    end else if (acc) begin
      took = 1'b1;
      sb_q.push_back(m_sel ? b : a);
      n_beats = m_beats + 4'd1;
      if (l[m_sel] || n_beats == 4'(MB)) begin
        n_busy = 1'b0;
        n_pri  = !m_sel;
      end
    end
    n_valid = took ? 1'b1 : ((m_valid && rd) ? 1'b0 : m_valid);
    @(posedge clk);
    m_busy = n_busy; m_sel = n_sel; m_pri = n_pri; m_beats = n_beats; m_valid = n_valid;
    @(negedge clk);
  endtask

  logic [1:0] exp_g1 [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic       exp_v1 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_d1 [5] = '{8'h00, 8'h3C, 8'h00, 8'hC3, 8'h00};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_sel", sel, 1'b0);
    chk("rst_valid", ov, 1'b0);
    chk("rst_data", od, 8'h00);
    rst_n = 1'b1;

    // Tie with continuous requests: four beats of requester 0, then requester 1.
    for (int i = 0; i < 14; i++) step(2'b11, 2'b00, 1'b1, 8'h10 + 8'(i), 8'h80 + 8'(i));

    // Single LAST beat from requester 1.
    repeat (2) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);
    step(2'b10, 2'b00, 1'b1, 8'h11, 8'hA5);
    step(2'b10, 2'b10, 1'b1, 8'h11, 8'hA5);
    repeat (3) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);

    // Backpressure while granted to requester 0.
    step(2'b01, 2'b00, 1'b1, 8'h21, 8'h00);
    step(2'b01, 2'b00, 1'b1, 8'h22, 8'h00);
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0, 8'h30 + 8'(i), 8'h00);
    step(2'b01, 2'b00, 1'b1, 8'h23, 8'h00);
    step(2'b01, 2'b01, 1'b1, 8'h24, 8'h00);
    repeat (3) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);

    // Requester 1 abandons after two beats.
    step(2'b10, 2'b00, 1'b1, 8'h00, 8'h41);
    step(2'b10, 2'b00, 1'b1, 8'h00, 8'h42);
    step(2'b10, 2'b00, 1'b1, 8'h00, 8'h43);
    step(2'b00, 2'b00, 1'b1, 8'h00, 8'h44);
    repeat (2) step(2'b11, 2'b00, 1'b1, 8'h55, 8'h66);
    repeat (3) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
           $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
    repeat (3) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);

    // Mid-burst reset with a beat held in the output register.
    step(2'b01, 2'b00, 1'b1, 8'h71, 8'h00);
    step(2'b01, 2'b00, 1'b0, 8'h72, 8'h00);
    step(2'b01, 2'b00, 1'b0, 8'h73, 8'h00);
    chk("pre_rst_valid", ov, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 2'b00);
    chk("async_rst_valid", ov, 1'b0);
    chk("async_rst_data", od, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(2'b11, 2'b00, 1'b1, 8'h81, 8'h82);
    repeat (5) step(2'b00, 2'b00, 1'b1, 8'h00, 8'h00);

    // Single-beat grants alternate on the MAX_BURST=1 instance.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 2'b00, 1'b1, 8'h3C, 8'hC3);
    for (int k = 0; k < 5; k++) begin
      chk("mb1_gnt", gnt1, exp_g1[k]);
      chk("mb1_valid", ov1, exp_v1[k]);
      if (exp_v1[k]) chk("mb1_data", od1, exp_d1[k]);
      step(2'b11, 2'b00, 1'b1, 8'h3C, 8'hC3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_arbiter_2.md
MUX_ARBITER_2 -- requirements
Module: mux_arbiter_2

Interface
REQ-001 Parameter W, default 8, width of each requester data word.
REQ-002 Parameter MAX_BURST, default 4, maximum beats per grant (range 1..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 REQ  input  2  REQ[i]=1: requester i has a valid beat on D[i].
REQ-006 LAST  input  2  LAST[i]=1: current beat of requester i ends its burst.
REQ-007 D0  input  W  requester 0 data.
REQ-008 D1  input  W  requester 1 data.
REQ-009 GNT  output  2  one-hot grant, or 0 when idle; a beat of i is taken when GNT[i]&REQ[i]&ACCEPT.
REQ-010 SEL  output  1  select driven to the 2:1 data mux; equals index of the granted requester.
REQ-011 OUT_VALID  output  1  OUT_DATA holds a valid beat.
REQ-012 OUT_READY  input  1  downstream accepts the beat when OUT_VALID&OUT_READY.
REQ-013 OUT_DATA  output  W  registered mux output.

Function
REQ-014 ACCEPT SHALL be ~OUT_VALID | OUT_READY (single output register, no skid buffer).
REQ-015 FSM SHALL have states IDLE and BUSY, encoded 1'b0 and 1'b1.
REQ-016 IDLE: if REQ!=0, winner SHALL be PRI when REQ[PRI]=1, else the other requester; next cycle state=BUSY, GNT=onehot(winner), SEL=winner, BEATS=0.
REQ-017 IDLE with REQ=0: GNT SHALL be 0 and SEL SHALL hold its last value.
REQ-018 Grant latency SHALL be exactly one cycle from REQ sampled in IDLE to GNT asserted.
REQ-019 BUSY: on each taken beat OUT_DATA SHALL load (SEL ? D1 : D0), OUT_VALID SHALL set, BEATS SHALL increment.
REQ-020 OUT_VALID SHALL clear when OUT_VALID&OUT_READY and no beat is taken that cycle; OUT_DATA SHALL hold while OUT_VALID&~OUT_READY.
REQ-021 BUSY SHALL end (next state IDLE, GNT=0) when a taken beat has LAST[SEL]=1 or BEATS+1==MAX_BURST.
REQ-022 BUSY SHALL end when REQ[SEL]=0 for a cycle (requester abandon), with no beat taken that cycle.
REQ-023 On every BUSY exit PRI SHALL become ~SEL (round-robin); no requester SHALL be granted twice in a row while the other is requesting.
REQ-024 REQ changes of the non-granted requester during BUSY SHALL have no effect until IDLE.
REQ-025 The arbiter SHALL always spend one IDLE cycle between grants (no back-to-back grant).
REQ-026 LAST without REQ on the granted requester SHALL be ignored.
REQ-027 BEATS counter SHALL be 4 bits; MAX_BURST=1 SHALL yield single-beat grants.

Reset
REQ-028 While RST_N=0: state=IDLE, GNT=0, SEL=0, PRI=0, BEATS=0, OUT_VALID=0, OUT_DATA=0.
REQ-029 Reset asserted mid-burst SHALL abort immediately; a pending OUT_DATA beat SHALL be discarded.
REQ-030 First arbitration after reset release SHALL favour requester 0 on tie.

Structure
REQ-031 A shared package SHALL hold state encodings IDLE/BUSY and the default W and MAX_BURST constants.
REQ-032 The data path SHALL instantiate the team's existing 2:1 mux (one instance per data bit, generate loop) driven by SEL, feeding the output register.
REQ-033 No other sub-modules.

Verification
REQ-034 Reset then REQ=2'b11, LAST=0, OUT_READY=1 -> GNT=01 cycle 1, 4 beats of D0 on OUT_DATA, IDLE, then GNT=10.
REQ-035 REQ=2'b10, D1=8'hA5, LAST[1]=1 on first beat -> single beat 8'hA5 out, OUT_VALID one cycle, PRI=0 after.
REQ-036 Granted to 0, OUT_READY=0 for 3 cycles -> OUT_DATA stable, GNT held, no beat lost, BEATS unchanged.
REQ-037 Granted to 1, REQ[1] drops after 2 beats -> IDLE next cycle, 2 beats out, PRI=0.
REQ-038 RST_N pulsed low mid-burst with OUT_VALID=1 -> GNT=0, OUT_VALID=0 asynchronously, tie after release grants 0.
REQ-039 MAX_BURST=1, REQ=2'b11 continuous -> grants alternate 01,00,10,00,01 with one beat each.
